// File: rtl/fifo_tile_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_tile_reader
// Brief    : Pops one tile of words from the array-operand FIFO and streams
//            them to the row feeder through a registered 2-entry buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_tile_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] tile_len,
    output logic             busy,
    output logic             done,
    output logic             fifo_rd_en,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic             fifo_wr_en_mon,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] pops_left_q, pops_left_d;
    logic [LEN_W-1:0] beats_left_q, beats_left_d;
    logic             inflight_q;
    logic [1:0]       occ_q, occ_d;
    logic             rd_ptr_q, wr_ptr_q;
    logic [WIDTH-1:0] buf_q [2];

    logic             w_beat;
    logic             w_room;
    logic             w_acc;
    logic [2:0]       w_occ_after;

    assign w_beat      = m_valid & m_ready;
    // The in-flight word already owns a slot, so it is counted before it lands.
    assign w_occ_after = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, w_beat};
    assign w_room      = (w_occ_after < 3'd2);
    assign fifo_rd_en  = (state_q == S_RUN) && (pops_left_q != '0) && !fifo_empty && w_room;
    // An accepted write wins over the read in the FIFO; that pop is retried later.
    assign w_acc       = fifo_rd_en & ~(fifo_wr_en_mon & ~fifo_full);

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf_q[rd_ptr_q];
    assign m_last  = m_valid && (beats_left_q == LEN_W'(1));
    assign busy    = (state_q == S_RUN) || (state_q == S_FIN);
    assign done    = (state_q == S_FIN);
    assign occ_d   = occ_q + {1'b0, inflight_q} - {1'b0, w_beat};

    always_comb begin
        state_d      = state_q;
        pops_left_d  = pops_left_q;
        beats_left_d = beats_left_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (tile_len != '0) begin
                        state_d      = S_RUN;
                        pops_left_d  = tile_len;
                        beats_left_d = tile_len;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RUN: begin
                if (w_acc && (pops_left_q != '0)) begin
                    pops_left_d = pops_left_q - LEN_W'(1);
                end
                if (w_beat && (beats_left_q != '0)) begin
                    beats_left_d = beats_left_q - LEN_W'(1);
                end
                if (w_beat && (beats_left_q == LEN_W'(1))) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pops_left_q  <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            pops_left_q  <= pops_left_d;
            beats_left_q <= beats_left_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            inflight_q <= w_acc;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_q ^ w_beat;
            wr_ptr_q   <= wr_ptr_q ^ inflight_q;
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= fifo_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_tile_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_tile_reader
// Brief    : Directed self-checking bench for fifo_tile_reader with a small
//            registered-output FIFO model that gives writes priority.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_tile_reader;

    localparam int WIDTH = 8;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] tile_len = '0;
    logic             busy, done, fifo_rd_en, m_valid, m_last;
    logic [WIDTH-1:0] m_data;
    logic             fifo_empty;
    logic             fifo_full = 1'b0;
    logic             fifo_wr_en_mon = 1'b0;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             m_ready = 1'b0;

    logic [WIDTH-1:0] wr_data = '0;
    logic             q_empty = 1'b1;
    logic             hold_empty = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] q [$];
    int               npops = 0;
    logic             last_pop = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_tile_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tile_len(tile_len),
        .busy(busy), .done(done), .fifo_rd_en(fifo_rd_en),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_wr_en_mon(fifo_wr_en_mon), .fifo_data(fifo_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    assign fifo_empty = q_empty | hold_empty;

    // FIFO model: registered data_out, write has priority over read.
    always @(posedge clk) begin
        logic wacc, racc;
        wacc = fifo_wr_en_mon & ~fifo_full;
        racc = fifo_rd_en & ~fifo_empty & ~wacc;
        if (flush) begin
            q.delete();
        end else begin
            if (racc) begin
                fifo_data <= q.pop_front();
                npops     <= npops + 1;
            end
            if (wacc) q.push_back(wr_data);
        end
        last_pop <= racc & ~flush;
        q_empty  <= (q.size() == 0);
    end

    // Output monitor: beat log, done log, stall stability, buffer occupancy.
    int               cyc = 0, nbeat = 0, ndone = 0, done_cyc = -1, nrd = 0;
    int               stall_viol = 0, ovf_cnt = 0;
    logic [WIDTH-1:0] b_data [64];
    logic             b_last [64];
    int               b_cyc  [64];
    logic             prev_stall = 1'b0, prev_last = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    int               occ_off = 0;
    logic             occ_en = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) nrd <= nrd + 1;
        if (done) begin
            ndone    <= ndone + 1;
            done_cyc <= cyc;
        end
        if (m_valid && m_ready) begin
            b_data[nbeat % 64] <= m_data;
            b_last[nbeat % 64] <= m_last;
            b_cyc[nbeat % 64]  <= cyc;
            nbeat              <= nbeat + 1;
        end
        if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
            stall_viol <= stall_viol + 1;
        prev_stall <= m_valid & ~m_ready;
        prev_data  <= m_data;
        prev_last  <= m_last;
        if (occ_en && (npops - int'(last_pop) - nbeat - occ_off) > 2)
            ovf_cnt <= ovf_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            wr_data        = base + WIDTH'(i);
            fifo_wr_en_mon = 1'b1;
            step();
        end
        fifo_wr_en_mon = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
    endtask

    task automatic begin_test();
        occ_off = npops - nbeat;
        occ_en  = 1'b1;
    endtask

    task automatic pulse_start(input int len, output int t);
        tile_len = LEN_W'(len);
        start    = 1'b1;
        t        = cyc;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic toggle, output logic ok);
        int d0;
        d0 = ndone;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ndone != d0) break;
            if (toggle) m_ready = ~m_ready;
            step();
        end
        ok = (ndone != d0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b expected 0", fifo_rd_en); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
        n_tests++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rst_m_data: got %h expected 00", m_data); end
        n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last: got %b expected 0", m_last); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero_len();
        int t, r0, d0;
        do_flush();
        preload(2, 8'hA0);
        begin_test();
        r0 = nrd;
        d0 = ndone;
        pulse_start(0, t);
        @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_t1: got %b expected 1", busy); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_t1: got %b expected 1", done); end
        step();
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_t2: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_t2: got %b expected 0", done); end
        for (int i = 0; i < 4; i++) step();
        n_tests++; if (nrd != r0) begin n_fail++; $display("FAIL zero_no_rd: got %0d rd_en cycles expected 0", nrd - r0); end
        n_tests++; if (ndone != d0 + 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d expected 1", ndone - d0); end
    endtask

    task automatic test_streaming();
        int t, b0, idx;
        logic ok;
        logic [WIDTH-1:0] exp;
        do_flush();
        preload(8, 8'h10);
        m_ready = 1'b1;
        begin_test();
        b0 = nbeat;
        pulse_start(8, t);
        @(negedge clk);
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL stream_rd_t1: got %b expected 1", fifo_rd_en); end
        wait_done(40, 1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stream_timeout: got no done expected done"); end
        n_tests++; if (nbeat - b0 != 8) begin n_fail++; $display("FAIL stream_beats: got %0d expected 8", nbeat - b0); end
        for (int i = 0; i < 8; i++) begin
            idx = (b0 + i) % 64;
            exp = 8'h10 + WIDTH'(i);
            n_tests++; if (b_data[idx] !== exp) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, b_data[idx], exp); end
            n_tests++; if (b_cyc[idx] != t + 3 + i) begin n_fail++; $display("FAIL stream_cyc[%0d]: got %0d expected %0d", i, b_cyc[idx] - t, 3 + i); end
            n_tests++; if (b_last[idx] !== (i == 7)) begin n_fail++; $display("FAIL stream_last[%0d]: got %b expected %b", i, b_last[idx], (i == 7)); end
        end
        n_tests++; if (done_cyc != t + 11) begin n_fail++; $display("FAIL stream_done_cyc: got t+%0d expected t+11", done_cyc - t); end
    endtask

    task automatic test_write_priority();
        int t, b0, p0, idx;
        logic ok;
        logic [WIDTH-1:0] exp;
        do_flush();
        preload(6, 8'h20);
        m_ready = 1'b1;
        begin_test();
        b0 = nbeat;
        p0 = npops;
        pulse_start(6, t);
        step();
        fifo_wr_en_mon = 1'b1;
        wr_data        = 8'hE0;
        @(negedge clk);
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL wpri_rd_req: got %b expected 1", fifo_rd_en); end
        step();
        wr_data = 8'hE1;
        step();
        wr_data = 8'hE2;
        step();
        fifo_wr_en_mon = 1'b0;
        wait_done(40, 1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wpri_timeout: got no done expected done"); end
        n_tests++; if (nbeat - b0 != 6) begin n_fail++; $display("FAIL wpri_beats: got %0d expected 6", nbeat - b0); end
        for (int i = 0; i < 6; i++) begin
            idx = (b0 + i) % 64;
            exp = 8'h20 + WIDTH'(i);
            n_tests++; if (b_data[idx] !== exp) begin n_fail++; $display("FAIL wpri_data[%0d]: got %h expected %h", i, b_data[idx], exp); end
            n_tests++; if (b_last[idx] !== (i == 5)) begin n_fail++; $display("FAIL wpri_last[%0d]: got %b expected %b", i, b_last[idx], (i == 5)); end
        end
        n_tests++; if (npops - p0 != 6) begin n_fail++; $display("FAIL wpri_pops: got %0d expected 6", npops - p0); end
        n_tests++; if (q.size() != 3) begin n_fail++; $display("FAIL wpri_left: got %0d expected 3", q.size()); end
    endtask

    task automatic test_backpressure();
        int t, b0, s0, o0, idx;
        logic ok;
        logic [WIDTH-1:0] exp;
        do_flush();
        preload(5, 8'h30);
        m_ready = 1'b1;
        begin_test();
        b0 = nbeat;
        s0 = stall_viol;
        o0 = ovf_cnt;
        pulse_start(5, t);
        wait_done(60, 1'b1, ok);
        m_ready = 1'b1;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no done expected done"); end
        n_tests++; if (nbeat - b0 != 5) begin n_fail++; $display("FAIL bp_beats: got %0d expected 5", nbeat - b0); end
        for (int i = 0; i < 5; i++) begin
            idx = (b0 + i) % 64;
            exp = 8'h30 + WIDTH'(i);
            n_tests++; if (b_data[idx] !== exp) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", i, b_data[idx], exp); end
            n_tests++; if (b_last[idx] !== (i == 4)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b expected %b", i, b_last[idx], (i == 4)); end
        end
        n_tests++; if (stall_viol != s0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol - s0); end
        n_tests++; if (ovf_cnt != o0) begin n_fail++; $display("FAIL bp_occ: got %0d cycles over 2 expected 0", ovf_cnt - o0); end
    endtask

    task automatic test_empty_stall();
        int t, b0, idx, rd_bad, v_bad;
        logic ok;
        logic [WIDTH-1:0] exp;
        do_flush();
        preload(8, 8'h40);
        m_ready = 1'b1;
        begin_test();
        b0 = nbeat;
        rd_bad = 0;
        v_bad  = 0;
        pulse_start(8, t);
        step();
        step();
        hold_empty = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_bad++;
            if (k >= 2 && m_valid) v_bad++;
            step();
        end
        hold_empty = 1'b0;
        n_tests++; if (rd_bad != 0) begin n_fail++; $display("FAIL empty_rd_en: got %0d cycles high expected 0", rd_bad); end
        n_tests++; if (v_bad != 0) begin n_fail++; $display("FAIL empty_m_valid: got %0d cycles high expected 0", v_bad); end
        n_tests++; if (nbeat - b0 != 2) begin n_fail++; $display("FAIL empty_pre_beats: got %0d expected 2", nbeat - b0); end
        wait_done(40, 1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL empty_timeout: got no done expected done"); end
        n_tests++; if (nbeat - b0 != 8) begin n_fail++; $display("FAIL empty_beats: got %0d expected 8", nbeat - b0); end
        for (int i = 0; i < 8; i++) begin
            idx = (b0 + i) % 64;
            exp = 8'h40 + WIDTH'(i);
            n_tests++; if (b_data[idx] !== exp) begin n_fail++; $display("FAIL empty_data[%0d]: got %h expected %h", i, b_data[idx], exp); end
        end
        n_tests++; if (b_last[(b0 + 7) % 64] !== 1'b1) begin n_fail++; $display("FAIL empty_last: got %b expected 1", b_last[(b0 + 7) % 64]); end
    endtask

    task automatic test_reset_mid();
        int t, b0, b1, d0, idx;
        logic ok;
        logic [WIDTH-1:0] exp;
        do_flush();
        preload(8, 8'h50);
        m_ready = 1'b1;
        begin_test();
        b0 = nbeat;
        d0 = ndone;
        pulse_start(8, t);
        for (int i = 0; i < 4; i++) step();
        n_tests++; if (nbeat - b0 != 2) begin n_fail++; $display("FAIL rmid_pre_beats: got %0d expected 2", nbeat - b0); end
        occ_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b expected 0", done); end
        n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rmid_rd_en: got %b expected 0", fifo_rd_en); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_m_valid: got %b expected 0", m_valid); end
        n_tests++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rmid_m_data: got %h expected 00", m_data); end
        n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rmid_m_last: got %b expected 0", m_last); end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_tests++; if (ndone != d0) begin n_fail++; $display("FAIL rmid_no_done: got %0d done pulses expected 0", ndone - d0); end
        do_flush();
        preload(3, 8'h60);
        begin_test();
        b1 = nbeat;
        pulse_start(3, t);
        wait_done(40, 1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout: got no done expected done"); end
        n_tests++; if (nbeat - b1 != 3) begin n_fail++; $display("FAIL rmid_beats: got %0d expected 3", nbeat - b1); end
        for (int i = 0; i < 3; i++) begin
            idx = (b1 + i) % 64;
            exp = 8'h60 + WIDTH'(i);
            n_tests++; if (b_data[idx] !== exp) begin n_fail++; $display("FAIL rmid_data[%0d]: got %h expected %h", i, b_data[idx], exp); end
            n_tests++; if (b_last[idx] !== (i == 2)) begin n_fail++; $display("FAIL rmid_last[%0d]: got %b expected %b", i, b_last[idx], (i == 2)); end
        end
        n_tests++; if (ndone != d0 + 1) begin n_fail++; $display("FAIL rmid_done_cnt: got %0d expected 1", ndone - d0); end
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_streaming();
        test_write_priority();
        test_backpressure();
        test_empty_stall();
        test_reset_mid();
        n_tests++; if (ovf_cnt != 0) begin n_fail++; $display("FAIL buf_overflow: got %0d cycles over 2 expected 0", ovf_cnt); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fifo_tile_reader.md
Name: fifo_tile_reader

Overview:
- Read-side controller for the array-operand FIFO. Once started, it pops exactly tile_len words from the FIFO and streams them to the systolic-array row feeder on a valid/ready interface.
- It marks the final word of the tile and pulses done when the tile has been consumed.
- It models the FIFO's write-priority rule: a read is not performed in any cycle where a write is accepted. The controller therefore tracks which of its pops were really accepted.

Parameters:
- WIDTH, 8, data word width; matches the FIFO WIDTH.
- LEN_W, 16, width of the tile-length counter; maximum tile is 2^LEN_W-1 words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a tile; sampled only in IDLE.
- tile_len  input  LEN_W  number of words to read; latched on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the final word is handshaken (or for a zero-length tile).
- fifo_rd_en  output  1  read enable to the FIFO.
- fifo_empty  input  1  FIFO empty flag.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en_mon  input  1  copy of the FIFO writer's wr_en, used to detect write priority.
- fifo_data  input  WIDTH  FIFO data_out (registered; valid the cycle after an accepted read).
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream ready.
- m_data  output  WIDTH  output word.
- m_last  output  1  high with the final word of the tile.

Behaviour:
- Reset (asynchronous, rst_n low): FSM goes to IDLE and all counters, the buffer and the in-flight flag clear. busy=0, done=0, fifo_rd_en=0, m_valid=0, m_data=0, m_last=0.
- Reset mid-tile abandons the tile with no done pulse. Words already popped are lost.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> RUN on start with tile_len!=0. On that transition, latch len, and clear pops_left=len and beats_left=len.
  - IDLE -> FIN on start with tile_len==0. No pop is issued.
  - RUN -> FIN on the m_valid & m_ready beat with beats_left==1.
  - FIN -> IDLE unconditionally. done=1 only in FIN.
- busy is high in RUN and FIN.
- start is ignored outside IDLE.
- Accepted pop: acc = fifo_rd_en & ~fifo_empty & ~(fifo_wr_en_mon & ~fifo_full).
  - pops_left decrements only on acc.
  - A pop that is not accepted is simply retried in a later cycle.
- inflight register: set to acc, one cycle deep. When inflight=1, fifo_data is captured into the buffer tail on that clock edge.
- Buffer: 2-entry FIFO holding words for the output. m_data and m_valid come from the buffer head, so the output is registered.
- fifo_rd_en = RUN & (pops_left!=0) & ~fifo_empty & (occ + inflight - (m_valid & m_ready) < 2).
  - The path from m_ready to fifo_rd_en is combinational.
  - With this rule, continuous m_ready and a never-empty FIFO give 1 word/cycle.
- Latency: with start accepted at cycle t, the FIFO non-empty and no writes:
  - fifo_rd_en is high at t+1.
  - fifo_data is valid at t+2.
  - m_valid is high at t+3.
- m_last = m_valid & (beats_left==1). m_data and m_last hold stable while m_valid & ~m_ready.
- The buffer never overflows; overflow is an assertion failure in the bench. The buffer never presents a word beyond len.
- Counter widths:
  - pops_left and beats_left are LEN_W bits.
  - occ is 2 bits.
  - No wrap: counters stop at 0.

Test Plan:
- Zero-length tile: start with tile_len=0 -> no fifo_rd_en ever; done pulses at t+1; busy high only at t+1.
- Streaming: FIFO preloaded with 0x10..0x17, tile_len=8, m_ready=1 -> m_data 0x10..0x17 on 8 consecutive cycles from t+3; m_last only on 0x17; done on the cycle after the last beat.
- Write priority: fifo_wr_en_mon=1 with fifo_full=0 during 3 cycles in which a read is requested -> those pops are not counted; all 6 words of tile_len=6 arrive in order, with no duplicate or skip.
- Backpressure: m_ready toggled 1/0 every cycle, tile_len=5 -> m_data stable while stalled; buffer occupancy never exceeds 2; exactly 5 beats.
- Empty stall: FIFO empty for 10 cycles mid-tile -> fifo_rd_en=0 and m_valid=0 until data returns; tile then completes.
- Reset mid-tile: rst_n low after 2 of 8 beats -> all outputs 0 immediately, no done; a new start with tile_len=3 then runs correctly.
